// File: rtl/reg_cut_pipe.sv
// reg_cut_pipe: register-interface cut with configurable request and response delay stages.
// Define REG_CUT_PIPE_TIMEOUT_EN to add an Issue-state watchdog (limit set by TimeoutCycles).
package reg_cut_pipe_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;

endpackage

module reg_cut_pipe #(
    parameter type         req_t         = reg_cut_pipe_pkg::reg_req_t,
    parameter type         rsp_t         = reg_cut_pipe_pkg::reg_rsp_t,
    parameter int unsigned ReqStages     = 1,
    parameter int unsigned RspStages     = 1,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  req_t src_req_i,
    output rsp_t src_rsp_o,
    output req_t dst_req_o,
    input  rsp_t dst_rsp_i,
    output logic busy_o
);

    if (ReqStages < 1 || ReqStages > 8 || RspStages < 1 || RspStages > 8 ||
        TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_param_check
        $error("reg_cut_pipe: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        REQ_DELAY,
        ISSUE,
        RSP_DELAY,
        RESPOND
    } state_t;

    // Loading Stages-1 and leaving the delay state when the counter reads 1
    // gives exactly Stages cycles between capture and the next phase.
    localparam logic [2:0] REQ_LOAD = 3'(ReqStages - 1);
    localparam logic [2:0] RSP_LOAD = 3'(RspStages - 1);

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    req_t       req_reg;
    rsp_t       rsp_reg;
    logic       capture_req;
    logic       capture_rsp;

`ifdef REG_CUT_PIPE_TIMEOUT_EN
    logic [15:0] wd_reg;
    logic        wd_expired;
    logic        timeout_hit;

    assign wd_expired  = (state_reg == ISSUE) && (wd_reg == 16'(TimeoutCycles - 1));
    // A real response arriving on the expiry cycle wins over the timeout.
    assign timeout_hit = wd_expired && !dst_rsp_i.ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_reg <= '0;
        end else if (state_reg == ISSUE) begin
            wd_reg <= wd_reg + 16'd1;
        end else begin
            wd_reg <= '0;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        capture_req = 1'b0;
        capture_rsp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (src_req_i.valid) begin
                    capture_req = 1'b1;
                    if (ReqStages == 1) begin
                        state_next = ISSUE;
                    end else begin
                        state_next = REQ_DELAY;
                        cnt_next   = REQ_LOAD;
                    end
                end
            end
            REQ_DELAY: begin
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg <= 3'd1) begin
                    state_next = ISSUE;
                    cnt_next   = '0;
                end
            end
            ISSUE: begin
                capture_rsp = dst_rsp_i.ready;
`ifdef REG_CUT_PIPE_TIMEOUT_EN
                if (capture_rsp || timeout_hit) begin
`else
                if (capture_rsp) begin
`endif
                    if (RspStages == 1) begin
                        state_next = RESPOND;
                    end else begin
                        state_next = RSP_DELAY;
                        cnt_next   = RSP_LOAD;
                    end
                end
            end
            RSP_DELAY: begin
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg <= 3'd1) begin
                    state_next = RESPOND;
                    cnt_next   = '0;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_reg <= '0;
            rsp_reg <= '0;
        end else begin
            if (capture_req) begin
                req_reg <= src_req_i;
            end
            if (capture_rsp) begin
                rsp_reg <= dst_rsp_i;
            end
`ifdef REG_CUT_PIPE_TIMEOUT_EN
            else if (timeout_hit) begin
                rsp_reg       <= '0;
                rsp_reg.error <= 1'b1;
            end
`endif
        end
    end

    // Handshake bits come from the state; payload always mirrors the held copies.
    always_comb begin
        dst_req_o       = req_reg;
        dst_req_o.valid = (state_reg == ISSUE);
        src_rsp_o       = rsp_reg;
        src_rsp_o.ready = (state_reg == RESPOND);
    end

    assign busy_o = (state_reg != IDLE);

endmodule

// File: tb/tb_reg_cut_pipe.sv
// Randomized bench for reg_cut_pipe: two instances (1/1 and 3/2 stages) checked
// cycle by cycle against a transaction-level timing model.
module tb_reg_cut_pipe;
    import reg_cut_pipe_pkg::*;

    localparam int S0 = 1;
    localparam int P0 = 1;
    localparam int S1 = 3;
    localparam int P1 = 2;
    localparam int TIMEOUT = 16;
`ifdef REG_CUT_PIPE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     rst;
    reg_req_t src_req [2];
    reg_rsp_t src_rsp [2];
    reg_req_t dst_req [2];
    reg_rsp_t dst_rsp [2];
    logic     busy    [2];
    reg_req_t prev_req [2];
    reg_rsp_t prev_rsp [2];
    int       n_cmp = 0;
    int       n_err = 0;
    int       n_txn = 0;

    always #5 clk = ~clk;

    reg_cut_pipe #(
        .req_t(reg_req_t), .rsp_t(reg_rsp_t),
        .ReqStages(S0), .RspStages(P0), .TimeoutCycles(TIMEOUT)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .src_req_i(src_req[0]), .src_rsp_o(src_rsp[0]),
        .dst_req_o(dst_req[0]), .dst_rsp_i(dst_rsp[0]),
        .busy_o(busy[0])
    );

    reg_cut_pipe #(
        .req_t(reg_req_t), .rsp_t(reg_rsp_t),
        .ReqStages(S1), .RspStages(P1), .TimeoutCycles(TIMEOUT)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .src_req_i(src_req[1]), .src_rsp_o(src_rsp[1]),
        .dst_req_o(dst_req[1]), .dst_rsp_i(dst_rsp[1]),
        .busy_o(busy[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_unit(input int u, input logic eb, input logic edv, input reg_req_t er,
                              input logic esr, input reg_rsp_t ersp);
        check($sformatf("u%0d busy", u),      busy[u],          eb);
        check($sformatf("u%0d dst_valid", u), dst_req[u].valid, edv);
        check($sformatf("u%0d dst_addr", u),  dst_req[u].addr,  er.addr);
        check($sformatf("u%0d dst_write", u), dst_req[u].write, er.write);
        check($sformatf("u%0d dst_wdata", u), dst_req[u].wdata, er.wdata);
        check($sformatf("u%0d dst_wstrb", u), dst_req[u].wstrb, er.wstrb);
        check($sformatf("u%0d src_ready", u), src_rsp[u].ready, esr);
        check($sformatf("u%0d src_rdata", u), src_rsp[u].rdata, ersp.rdata);
        check($sformatf("u%0d src_error", u), src_rsp[u].error, ersp.error);
    endtask

    function automatic reg_req_t mk_req(input logic [31:0] addr, input logic wr,
                                        input logic [31:0] wdata, input logic [3:0] wstrb);
        reg_req_t r;
        r.valid = 1'b1;
        r.addr  = addr;
        r.write = wr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        return r;
    endfunction

    function automatic reg_req_t rand_req();
        return mk_req($urandom, 1'($urandom), $urandom, 4'($urandom));
    endfunction

    function automatic reg_rsp_t mk_rsp(input logic [31:0] rdata, input logic err);
        reg_rsp_t r;
        r.ready = 1'b1;
        r.rdata = rdata;
        r.error = err;
        return r;
    endfunction

    task automatic rand_dst_rsp(input int u);
        dst_rsp[u].ready = 1'($urandom);
        dst_rsp[u].rdata = $urandom;
        dst_rsp[u].error = 1'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                check_unit(u, 1'b0, 1'b0, prev_req[u], 1'b0, prev_rsp[u]);
                src_req[u].valid = 1'b0;
                rand_dst_rsp(u);
            end
        end
    endtask

    // Cycle 0 is the Idle cycle in which src valid is sampled. The target answers
    // after w wait cycles; abort_at >= 0 pulses reset in that cycle instead.
    task automatic run_txn(input int u, input reg_req_t rq, input int w, input reg_rsp_t rs,
                           input bit hold, input int abort_at);
        int       s;
        int       p;
        int       w_eff;
        int       last;
        bit       to_hit;
        reg_rsp_t exp_rsp;
        s       = (u == 0) ? S0 : S1;
        p       = (u == 0) ? P0 : P1;
        to_hit  = TO_EN && (w >= TIMEOUT);
        w_eff   = to_hit ? TIMEOUT - 1 : w;
        last    = s + w_eff + p;
        exp_rsp = rs;
        if (to_hit) begin
            exp_rsp.rdata = '0;
            exp_rsp.error = 1'b1;
        end
        for (int t = 0; t <= last; t++) begin
            @(negedge clk);
            check_unit(u, t > 0, (t >= s) && (t <= s + w_eff), (t == 0) ? prev_req[u] : rq,
                       t == last, (t <= s + w_eff) ? prev_rsp[u] : exp_rsp);
            if (t == abort_at) begin
                rst = 1'b1;
                src_req[u].valid = 1'b0;
                #1;
                check_unit(u, 1'b0, 1'b0, '0, 1'b0, '0);
                @(negedge clk);
                check_unit(u, 1'b0, 1'b0, '0, 1'b0, '0);
                rst = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    prev_req[k] = '0;
                    prev_rsp[k] = '0;
                end
                n_txn++;
                $display("txn %0d unit=%0d addr=%h aborted by reset at cycle %0d", n_txn, u, rq.addr, t);
                return;
            end
            if (t == 0) begin
                src_req[u] = rq;
                src_req[u].valid = 1'b1;
            end else begin
                src_req[u].valid = hold ? 1'b1 : ((t == last) ? 1'b0 : 1'($urandom));
                src_req[u].addr  = $urandom;
                src_req[u].write = 1'($urandom);
                src_req[u].wdata = $urandom;
                src_req[u].wstrb = 4'($urandom);
            end
            if (t >= s && t <= s + w_eff) begin
                dst_rsp[u].ready = (t == s + w) && !to_hit;
                dst_rsp[u].rdata = dst_rsp[u].ready ? rs.rdata : $urandom;
                dst_rsp[u].error = dst_rsp[u].ready ? rs.error : 1'($urandom);
            end else begin
                rand_dst_rsp(u);
            end
        end
        prev_req[u] = rq;
        prev_rsp[u] = exp_rsp;
        n_txn++;
        $display("txn %0d unit=%0d addr=%h wr=%0b wdata=%h wait=%0d rdata=%h err=%0b hold=%0b",
                 n_txn, u, rq.addr, rq.write, rq.wdata, w, exp_rsp.rdata, exp_rsp.error, hold);
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            src_req[u]  = '0;
            dst_rsp[u]  = '0;
            prev_req[u] = '0;
            prev_rsp[u] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                check_unit(u, 1'b0, 1'b0, '0, 1'b0, '0);
                src_req[u] = rand_req();
                rand_dst_rsp(u);
            end
        end
        for (int u = 0; u < 2; u++) src_req[u].valid = 1'b0;
        rst = 1'b0;

        // Single-stage read, zero-wait target
        run_txn(0, mk_req(32'h40, 1'b0, 32'h0, 4'h0), 0, mk_rsp(32'hDEADBEEF, 1'b0), 1'b0, -1);
        idle_cycles(1);
        // 3/2 stages, write with four wait cycles; src fields scramble during ReqDelay
        run_txn(1, mk_req(32'h40, 1'b1, 32'h12345678, 4'hF), 4, mk_rsp($urandom, 1'b0), 1'b0, -1);
        idle_cycles(2);

        for (int i = 0; i < 40; i++) begin
            run_txn($urandom_range(0, 1), rand_req(), $urandom_range(0, 6),
                    mk_rsp($urandom, 1'($urandom)), 1'b0, -1);
            idle_cycles($urandom_range(0, 2));
        end

        // Long waits: timeout (when enabled) and ready exactly at the expiry cycle
        run_txn(0, rand_req(), 20, mk_rsp($urandom, 1'b0), 1'b0, -1);
        run_txn(1, rand_req(), TIMEOUT - 1, mk_rsp($urandom, 1'b0), 1'b0, -1);
        run_txn(1, rand_req(), TIMEOUT + 3, mk_rsp($urandom, 1'b0), 1'b0, -1);
        idle_cycles(1);

        // Reset pulses during Issue, each followed by a normal transaction
        run_txn(1, rand_req(), 4, mk_rsp($urandom, 1'b0), 1'b0, 4);
        run_txn(1, rand_req(), 1, mk_rsp($urandom, 1'b1), 1'b0, -1);
        run_txn(0, rand_req(), 2, mk_rsp($urandom, 1'b0), 1'b0, 1);
        run_txn(0, rand_req(), 0, mk_rsp($urandom, 1'b0), 1'b0, -1);
        idle_cycles(1);

        // Back-to-back with src valid held high
        for (int i = 0; i < 10; i++) begin
            run_txn(1, rand_req(), $urandom_range(0, 3), mk_rsp($urandom, 1'($urandom)), 1'b1, -1);
        end
        idle_cycles(1);
        for (int i = 0; i < 10; i++) begin
            run_txn(0, rand_req(), $urandom_range(0, 2), mk_rsp($urandom, 1'($urandom)), 1'b1, -1);
        end
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
